hmem_arbiter: RTL and testbench

Two-requester arbiter sharing one higher-memory port between the instruction cache and the data cache miss paths. It grants the port for a whole cache-line burst, counts beats, and releases on the final beat or on requester abort. It sits between the icache/dcache higher-memory sides and the single backing-memory port.

---
 rtl/hmem_arbiter_if.sv | 41 ++++
 rtl/hmem_arbiter.sv | 93 +++++++++
 tb/tb_hmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hmem_arbiter_if.sv
// Reset and bus interfaces for hmem_arbiter: both cache miss sides plus the backing-memory port.
// The slave modports are the arbiter's view; master modports belong to the surrounding logic.
interface hmem_rst_if;
  logic reset;

  modport master (output reset);
  modport slave  (input  reset);
endinterface

interface hmem_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_done;
  logic [XLEN-1:0] i_rdata;

  logic            d_req;
  logic [XLEN-1:0] d_addr;
  logic            d_we;
  logic [XLEN-1:0] d_wdata;
  logic            d_done;
  logic [XLEN-1:0] d_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_done;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_done, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_done, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/hmem_arbiter.sv
// Burst-granular arbiter giving icache/dcache miss paths one shared higher-memory port.
// Define HMEM_ARB_DCACHE_PRIO_EN for fixed dcache priority; default is round-robin.
module hmem_arbiter #(
  parameter int unsigned LINE_SIZE = 32,
  parameter int unsigned XLEN      = 32
) (
  input logic           clk,
  hmem_rst_if.slave     rst_if,
  hmem_arbiter_if.slave bus
);
  localparam int unsigned WORDS_PER_LINE = LINE_SIZE / (XLEN / 8);
  localparam int unsigned CntW           = $clog2(WORDS_PER_LINE);
  localparam logic [CntW-1:0] LastBeat   = CntW'(WORDS_PER_LINE - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOwnI = 2'd1;
  localparam logic [1:0] StOwnD = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] beat_q, beat_d;
  logic            own_i, own_d, owner_req, final_beat, release_own, pick_d;

  // Reset forces every port output low in the same cycle, regardless of the held state.
  assign own_i     = (state_q == StOwnI) & ~rst_if.reset;
  assign own_d     = (state_q == StOwnD) & ~rst_if.reset;
  assign owner_req = (own_i & bus.i_req) | (own_d & bus.d_req);

  // A done landing in the cycle the owner drops its request belongs to an abandoned beat.
  assign bus.i_done  = own_i & bus.i_req & bus.mem_done;
  assign bus.d_done  = own_d & bus.d_req & bus.mem_done;
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

  assign bus.mem_req   = owner_req;
  assign bus.mem_we    = own_d & bus.d_we;
  assign bus.mem_addr  = own_i ? bus.i_addr : (own_d ? bus.d_addr : '0);
  assign bus.mem_wdata = own_d ? bus.d_wdata : '0;

  assign final_beat  = owner_req & bus.mem_done & (beat_q == LastBeat);
  assign release_own = (own_i & ~bus.i_req) | (own_d & ~bus.d_req) | final_beat;

`ifdef HMEM_ARB_DCACHE_PRIO_EN
  assign pick_d = bus.d_req;
`else
  logic last_d_q;  // 1: dcache held the port most recently

  assign pick_d = bus.d_req & (~bus.i_req | ~last_d_q);

  always_ff @(posedge clk) begin
    if (rst_if.reset) begin
      last_d_q <= 1'b1;
    end else if (release_own) begin
      last_d_q <= own_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      StIdle: begin
        beat_d = '0;
        if (bus.i_req | bus.d_req) begin
          state_d = pick_d ? StOwnD : StOwnI;
        end
      end
      StOwnI, StOwnD: begin
        if (release_own) begin
          state_d = StIdle;
          beat_d  = '0;
        end else if (bus.mem_done) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_if.reset) begin
      state_q <= StIdle;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_hmem_arbiter.sv
// Self-checking bench for hmem_arbiter: burst-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_hmem_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int          WPL  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  hmem_rst_if                    rif ();
  hmem_arbiter_if #(.XLEN(XLEN)) bif ();

  hmem_arbiter #(.LINE_SIZE(32), .XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_if (rif),
    .bus    (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the port, beats finished in this burst, who held it last.
  int m_owner = 0;  // 0 none, 1 icache, 2 dcache
  int m_beats = 0;
  bit m_last_d = 1'b1;
  bit m_valid = 1'b0;

  int nd, nd_d, cyc, ib, db, last_done_cyc, bad;
  bit di, dd;
  int seq[$];
  int exp_seq[4];
  logic [31:0] exp_addr, exp_wdata, last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic        e_req, e_we, e_id, e_dd, req;
    logic [31:0] e_addr, e_wdata;
    e_req = 1'b0; e_we = 1'b0; e_id = 1'b0; e_dd = 1'b0;
    e_addr = '0; e_wdata = '0;
    if (rif.reset) m_valid = 1'b1;
    if (!m_valid) return;
    if (!rif.reset && m_owner == 1) begin
      e_req  = bif.i_req;
      e_addr = bif.i_addr;
      e_id   = bif.i_req & bif.mem_done;
    end else if (!rif.reset && m_owner == 2) begin
      e_req   = bif.d_req;
      e_addr  = bif.d_addr;
      e_we    = bif.d_we;
      e_wdata = bif.d_wdata;
      e_dd    = bif.d_req & bif.mem_done;
    end
    chk("mem_req",   32'(bif.mem_req),  32'(e_req));
    chk("mem_we",    32'(bif.mem_we),   32'(e_we));
    chk("mem_addr",  bif.mem_addr,      e_addr);
    chk("mem_wdata", bif.mem_wdata,     e_wdata);
    chk("i_done",    32'(bif.i_done),   32'(e_id));
    chk("d_done",    32'(bif.d_done),   32'(e_dd));
    chk("i_rdata",   bif.i_rdata,       bif.mem_rdata);
    chk("d_rdata",   bif.d_rdata,       bif.mem_rdata);
    if (rif.reset) begin
      m_owner = 0; m_beats = 0; m_last_d = 1'b1;
    end else if (m_owner == 0) begin
      m_beats = 0;
      if (bif.i_req && bif.d_req) begin
`ifdef HMEM_ARB_DCACHE_PRIO_EN
        m_owner = 2;
`else
        m_owner = m_last_d ? 1 : 2;
`endif
      end else if (bif.i_req) m_owner = 1;
      else if (bif.d_req) m_owner = 2;
    end else begin
      req = (m_owner == 1) ? bif.i_req : bif.d_req;
      if (!req) begin
        m_last_d = (m_owner == 2); m_owner = 0; m_beats = 0;
      end else if (bif.mem_done) begin
        m_beats++;
        if (m_beats == WPL) begin
          m_last_d = (m_owner == 2); m_owner = 0; m_beats = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rif.reset = 1'b1;
    bif.i_req = 1'b0; bif.d_req = 1'b0; bif.d_we = 1'b0; bif.mem_done = 1'b0;
    @(posedge clk); #1;
    rif.reset = 1'b0;
  endtask

  // Runs an icache burst with mem_done held high until 'beats' dones or the cycle budget.
  task automatic run_i(input int beats, output int n, output int c);
    n = 0; c = 0;
    while (n < beats && c < 40) begin
      @(negedge clk); c++; di = bif.i_done;
      @(posedge clk); #1;
      if (di) begin n++; bif.i_addr = bif.i_addr + 32'd4; end
    end
  endtask

  initial begin
    rif.reset = 1'b1;
    bif.i_req = 1'b0; bif.i_addr = '0; bif.d_req = 1'b0; bif.d_addr = '0;
    bif.d_we = 1'b0; bif.d_wdata = '0; bif.mem_done = 1'b0; bif.mem_rdata = 32'hA5A5_0001;
    fork
      forever begin
        @(negedge clk);
        model_step();
      end
    join_none
    @(posedge clk); #1;

    // Single icache burst, zero-wait memory.
    do_reset();
    @(negedge clk);
    chk("reset_idle_req", 32'(bif.mem_req), 32'd0);
    @(posedge clk); #1;
    bif.i_req = 1'b1; bif.i_addr = 32'h2000; bif.mem_done = 1'b1;
    run_i(8, nd, cyc);
    chk("t1_beats", 32'(nd), 32'd8);
    chk("t1_cycles", 32'(cyc), 32'd9);
    @(negedge clk);
    chk("t1_release", 32'(bif.mem_req), 32'd0);
    @(posedge clk); #1;

    // Simultaneous requests from reset, held for four bursts.
    do_reset();
    bif.i_req = 1'b1; bif.d_req = 1'b1; bif.d_we = 1'b1;
    bif.i_addr = 32'h0100; bif.d_addr = 32'h0800; bif.d_wdata = $urandom; bif.mem_done = 1'b1;
    ib = 0; db = 0; cyc = 0; last_done_cyc = 0; bad = 0; seq.delete();
    while (seq.size() < 4 && cyc < 100) begin
      @(negedge clk); cyc++; di = bif.i_done; dd = bif.d_done;
      if ((dd && !bif.mem_we) || (di && bif.mem_we)) bad++;
      if (di || dd) last_done_cyc = cyc;
      if (di) begin ib++; if (ib == WPL) begin seq.push_back(1); ib = 0; end end
      if (dd) begin db++; if (db == WPL) begin seq.push_back(2); db = 0; end end
      @(posedge clk); #1;
      if (di) bif.i_addr = bif.i_addr + 32'd4;
      if (dd) begin bif.d_addr = bif.d_addr + 32'd4; bif.d_wdata = $urandom; end
    end
`ifdef HMEM_ARB_DCACHE_PRIO_EN
    exp_seq = '{2, 2, 2, 2};
`else
    exp_seq = '{1, 2, 1, 2};
`endif
    chk("t3_bursts", 32'(seq.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_owner%0d", k), 32'((seq.size() > k) ? seq[k] : 0), 32'(exp_seq[k]));
    end
    chk("t3_timing", 32'(last_done_cyc), 32'd36);
    chk("t3_we", 32'(bad), 32'd0);

    // Dcache aborts after three beats with a done on the drop cycle; icache waiting.
    do_reset();
    bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h3000; bif.mem_done = 1'b1;
    nd = 0; cyc = 0;
    while (nd < 3 && cyc < 20) begin
      @(negedge clk); cyc++; dd = bif.d_done;
      @(posedge clk); #1;
      if (dd) begin nd++; bif.d_addr = bif.d_addr + 32'd4; end
    end
    bif.d_req = 1'b0; bif.i_req = 1'b1; bif.i_addr = 32'h4000;
    @(negedge clk);
    chk("t4_drop_done", 32'(bif.d_done), 32'd0);
    chk("t4_drop_req", 32'(bif.mem_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_idle", 32'(bif.mem_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_grant_i", 32'(bif.mem_req), 32'd1);
    chk("t4_grant_addr", bif.mem_addr, 32'h4000);
    nd = bif.i_done ? 1 : 0;
    @(posedge clk); #1;
    if (nd == 1) bif.i_addr = bif.i_addr + 32'd4;
    run_i(7, ib, cyc);
    chk("t4_full_burst", 32'(cyc), 32'd7);
    @(negedge clk);
    chk("t4_release", 32'(bif.mem_req), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of an icache burst.
    do_reset();
    bif.i_req = 1'b1; bif.i_addr = 32'h5000; bif.mem_done = 1'b1;
    run_i(5, nd, cyc);
    rif.reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_req", 32'(bif.mem_req), 32'd0);
    chk("t5_rst_done", 32'(bif.i_done), 32'd0);
    chk("t5_rst_addr", bif.mem_addr, 32'd0);
    @(posedge clk); #1;
    rif.reset = 1'b0; bif.i_addr = 32'h5000;
    run_i(8, nd, cyc);
    chk("t5_cycles", 32'(cyc), 32'd9);
    @(negedge clk);
    chk("t5_release", 32'(bif.mem_req), 32'd0);
    @(posedge clk); #1;

    // Dcache writeback against a memory that completes every third cycle.
    do_reset();
    bif.d_req = 1'b1; bif.d_we = 1'b1; bif.d_addr = 32'h1000; bif.d_wdata = $urandom;
    exp_wdata = bif.d_wdata; bif.mem_done = 1'b0;
    nd = 0; cyc = 0; bad = 0; last_addr = '0;
    while (nd < 8 && cyc < 60) begin
      @(negedge clk); cyc++; dd = bif.d_done;
      exp_addr = 32'h1000 + 32'(4 * nd);
      if (bif.mem_req && (bif.mem_addr !== exp_addr || bif.mem_wdata !== exp_wdata)) bad++;
      if (dd) last_addr = bif.mem_addr;
      @(posedge clk); #1;
      if (dd) begin
        nd++; bif.d_addr = bif.d_addr + 32'd4; bif.d_wdata = $urandom; exp_wdata = bif.d_wdata;
      end
      bif.mem_done = ((cyc + 1) % 3 == 0);
    end
    chk("t6_cycles", 32'(cyc), 32'd24);
    chk("t6_hold", 32'(bad), 32'd0);
    chk("t6_last_addr", last_addr, 32'h101C);
    bif.mem_done = 1'b0;
    @(negedge clk);
    chk("t6_release", 32'(bif.mem_req), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic with aborts, wait states and occasional resets.
    do_reset();
    ib = 0; db = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); di = bif.i_done; dd = bif.d_done;
      @(posedge clk); #1;
      rif.reset = ($urandom_range(0, 299) == 0);
      if (bif.i_req) begin
        if (di) begin
          ib++; bif.i_addr = bif.i_addr + 32'd4;
          if (ib == WPL) begin ib = 0; if ($urandom_range(0, 1) == 0) bif.i_req = 1'b0; end
        end else if ($urandom_range(0, 59) == 0) bif.i_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        bif.i_req = 1'b1; bif.i_addr = $urandom & 32'hFFFF_FFE0; ib = 0;
      end
      if (bif.d_req) begin
        if (dd) begin
          db++; bif.d_addr = bif.d_addr + 32'd4; bif.d_wdata = $urandom;
          if (db == WPL) begin db = 0; if ($urandom_range(0, 1) == 0) bif.d_req = 1'b0; end
        end else if ($urandom_range(0, 59) == 0) bif.d_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        bif.d_req = 1'b1; bif.d_addr = $urandom & 32'hFFFF_FFE0; db = 0;
        bif.d_we = 1'($urandom_range(0, 1)); bif.d_wdata = $urandom;
      end
      bif.mem_done = ($urandom_range(0, 2) != 0);
      bif.mem_rdata = $urandom;
    end
    rif.reset = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
